// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using the iterative shift-and-add-3
//   (double-dabble) algorithm. It processes one input bit per clock, so a
//   conversion takes BIN_W cycles. The converter has a start/busy/done
//   handshake, a leading-zero blank mask for the display mux, and an overflow
//   flag. When the value does not fit in DIGITS digits, the output saturates
//   to all nines.
//
// Parameters
//   BIN_W   binary input width (>= 4)
//   DIGITS  number of BCD digits produced (>= 1); digit 0 = units
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   start  in   conversion request, sampled only while idle
//   bin    in   unsigned value, captured on the accepted start edge
//   busy   out  high while a conversion is in progress
//   done   out  one-cycle pulse; bcd/blank/ovf are valid from this cycle on
//   bcd    out  result, digit i = bcd[4*i+3:4*i], held until the next done
//   blank  out  1 = digit i is a leading zero; blank[0] is always 0
//   ovf    out  last result exceeded 10^DIGITS-1 (bcd saturated to nines)
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    // All digits blanked except the units digit.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   sr_q, sr_d;
    logic [BCD_W-1:0]   chain_q, chain_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               ovf_q, ovf_d;

    // One iteration of the algorithm, computed combinationally from the
    // current chain contents.
    logic [BCD_W-1:0]   chain_adj;
    logic [BCD_W-1:0]   chain_shift;
    logic [BIN_W-1:0]   sr_shift;
    logic               shift_out;
    logic               ovf_final;
    logic [BCD_W-1:0]   bcd_final;
    logic [DIGITS-1:0]  blank_final;

    // Add 3 to each digit that is >= 5. The digits do not carry into each
    // other. After the shift, the digit then carries correctly into the next
    // decade.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        logic [3:0] digit;
        assign digit = chain_q[4*gi +: 4];
        assign chain_adj[4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

    assign chain_shift = {chain_adj[BCD_W-2:0], sr_q[BIN_W-1]};
    assign sr_shift    = {sr_q[BIN_W-2:0], 1'b0};
    // A bit leaving the top digit means the running value has reached
    // 10^DIGITS. The flag is sticky for the rest of the conversion.
    assign shift_out   = chain_adj[BCD_W-1];
    assign ovf_final   = ovf_flag_q | shift_out;
    assign bcd_final   = ovf_final ? {DIGITS{4'h9}} : chain_shift;

    // Digit i is blanked when it and every digit above it are zero.
    // The scan runs from the top digit down.
    always_comb begin
        logic zero_above;
        blank_final = '0;
        zero_above  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above     = zero_above & (bcd_final[4*i +: 4] == 4'd0);
            blank_final[i] = zero_above;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        chain_d    = chain_q;
        ovf_flag_d = ovf_flag_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d       = bin;
                    chain_d    = '0;
                    ovf_flag_d = 1'b0;
                    cnt_d      = CNT_W'(BIN_W);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                chain_d    = chain_shift;
                sr_d       = sr_shift;
                ovf_flag_d = ovf_final;
                cnt_d      = cnt_q - CNT_W'(1);
                // The counter reaches zero on this edge, so this is the
                // last iteration. Publish the post-iteration result.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = bcd_final;
                    blank_d = blank_final;
                    ovf_d   = ovf_final;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            chain_q    <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            chain_q    <= chain_d;
            ovf_flag_q <= ovf_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Testbench for bin_to_bcd_seq with two instances: the default size
//   (14 bits, 4 digits) and a wide size (20 bits, 6 digits). A behavioural
//   model computes the expected results with decimal arithmetic and a
//   latency count. One compare process checks every output of both instances
//   on every cycle. Directed conversions also check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: BIN_W=14, DIGITS=4
    logic        a_start = 1'b0;
    logic [13:0] a_bin   = '0;
    logic        a_busy, a_done, a_ovf;
    logic [15:0] a_bcd;
    logic [3:0]  a_blank;

    // Instance B: BIN_W=20, DIGITS=6
    logic        b_start = 1'b0;
    logic [19:0] b_bin   = '0;
    logic        b_busy, b_done, b_ovf;
    logic [23:0] b_bcd;
    logic [5:0]  b_blank;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .bin(a_bin),
        .busy(a_busy), .done(a_done), .bcd(a_bcd), .blank(a_blank), .ovf(a_ovf)
    );

    bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .bin(b_bin),
        .busy(b_busy), .done(b_done), .bcd(b_bcd), .blank(b_blank), .ovf(b_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint pow10(input int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    // Decimal digits of v, or all nines if v does not fit in d digits.
    function automatic logic [23:0] exp_bcd(input longint v, input int d);
        logic [23:0] r = '0;
        longint x = v;
        if (v > pow10(d) - 1) begin
            for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
        end else begin
            for (int i = 0; i < d; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    // Digit i (i >= 1) is a leading zero exactly when the shown value < 10^i.
    function automatic logic [5:0] exp_blank(input longint v, input int d);
        logic [5:0] r = '0;
        longint shown = (v > pow10(d) - 1) ? pow10(d) - 1 : v;
        for (int i = 1; i < d; i++) r[i] = (shown < pow10(i));
        return r;
    endfunction

    logic        ma_busy = 0, ma_done = 0, ma_ovf = 0;
    logic [15:0] ma_bcd = '0;
    logic [3:0]  ma_blank = 4'b1110;
    int          ma_cnt = 0;
    longint      ma_val = 0;
    logic [23:0] ta24;
    logic [5:0]  ta6;

    always @(posedge clk) begin
        if (rst) begin
            ma_busy = 0; ma_done = 0; ma_ovf = 0; ma_bcd = '0; ma_blank = 4'b1110; ma_cnt = 0;
        end else begin
            ma_done = 0;
            if (ma_busy) begin
                ma_cnt--;
                if (ma_cnt == 0) begin
                    ma_busy  = 0;
                    ma_done  = 1;
                    ta24     = exp_bcd(ma_val, 4);
                    ta6      = exp_blank(ma_val, 4);
                    ma_bcd   = ta24[15:0];
                    ma_blank = ta6[3:0];
                    ma_ovf   = (ma_val > 9999);
                end
            end else if (a_start) begin
                ma_val  = longint'(a_bin);
                ma_busy = 1;
                ma_cnt  = 14;
            end
        end
    end

    logic        mb_busy = 0, mb_done = 0, mb_ovf = 0;
    logic [23:0] mb_bcd = '0;
    logic [5:0]  mb_blank = 6'b111110;
    int          mb_cnt = 0;
    longint      mb_val = 0;

    always @(posedge clk) begin
        if (rst) begin
            mb_busy = 0; mb_done = 0; mb_ovf = 0; mb_bcd = '0; mb_blank = 6'b111110; mb_cnt = 0;
        end else begin
            mb_done = 0;
            if (mb_busy) begin
                mb_cnt--;
                if (mb_cnt == 0) begin
                    mb_busy  = 0;
                    mb_done  = 1;
                    mb_bcd   = exp_bcd(mb_val, 6);
                    mb_blank = exp_blank(mb_val, 6);
                    mb_ovf   = (mb_val > 999999);
                end
            end else if (b_start) begin
                mb_val  = longint'(b_bin);
                mb_busy = 1;
                mb_cnt  = 20;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        chk("a_busy",  24'(a_busy),  24'(ma_busy));
        chk("a_done",  24'(a_done),  24'(ma_done));
        chk("a_bcd",   24'(a_bcd),   24'(ma_bcd));
        chk("a_blank", 24'(a_blank), 24'(ma_blank));
        chk("a_ovf",   24'(a_ovf),   24'(ma_ovf));
        chk("b_busy",  24'(b_busy),  24'(mb_busy));
        chk("b_done",  24'(b_done),  24'(mb_done));
        chk("b_bcd",   b_bcd,        mb_bcd);
        chk("b_blank", 24'(b_blank), 24'(mb_blank));
        chk("b_ovf",   24'(b_ovf),   24'(mb_ovf));
    end

    // ---------------- directed stimulus ----------------
    // One conversion on instance A (sel=0) or B (sel=1). Checks the latency
    // from the start edge to done and the literal result. bin is disturbed
    // right after capture.
    task automatic conv(input bit sel, input int v, input logic [23:0] eb,
                        input logic [5:0] ebl, input logic eo, input int lat);
        int j;
        bit seen;
        @(negedge clk);
        if (sel) begin b_bin = 20'(v); b_start = 1'b1; end
        else     begin a_bin = 14'(v); a_start = 1'b1; end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        a_bin = ~a_bin;
        b_bin = ~b_bin;
        j = 0;
        seen = 0;
        while (!seen && j < 40) begin
            @(negedge clk);
            j++;
            seen = sel ? b_done : a_done;
        end
        chk("latency", 24'(j), 24'(lat));
        if (sel) begin
            chk("lit_bcd",   b_bcd,          eb);
            chk("lit_blank", 24'(b_blank),   24'(ebl));
            chk("lit_ovf",   24'(b_ovf),     24'(eo));
            $display("conv B bin=%0d bcd=%h blank=%b ovf=%b latency=%0d", v, b_bcd, b_blank, b_ovf, j);
        end else begin
            chk("lit_bcd",   24'(a_bcd),     eb);
            chk("lit_blank", 24'(a_blank),   24'(ebl));
            chk("lit_ovf",   24'(a_ovf),     24'(eo));
            $display("conv A bin=%0d bcd=%h blank=%b ovf=%b latency=%0d", v, a_bcd, a_blank, a_ovf, j);
        end
    endtask

    initial begin
        int dones;
        int first_done;
        int last_done;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_a_busy",  24'(a_busy),  24'd0);
        chk("rst_a_done",  24'(a_done),  24'd0);
        chk("rst_a_bcd",   24'(a_bcd),   24'h0);
        chk("rst_a_blank", 24'(a_blank), 24'b1110);
        chk("rst_a_ovf",   24'(a_ovf),   24'd0);
        chk("rst_b_blank", 24'(b_blank), 24'b111110);
        rst = 1'b0;

        // Instance A directed values
        conv(0, 9999,  24'h009999, 6'b0000, 1'b0, 14);
        conv(0, 42,    24'h000042, 6'b1100, 1'b0, 14);
        conv(0, 0,     24'h000000, 6'b1110, 1'b0, 14);
        conv(0, 12345, 24'h009999, 6'b0000, 1'b1, 14);
        conv(0, 16383, 24'h009999, 6'b0000, 1'b1, 14);
        conv(0, 7,     24'h000007, 6'b1110, 1'b0, 14);

        // start held high with bin changing every cycle
        @(negedge clk);
        a_start = 1'b1;
        a_bin = 14'd100;
        dones = 0;
        first_done = -1;
        last_done = -1;
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            a_bin = 14'((j * 611) % 16384);
            if (a_done) begin
                dones++;
                if (first_done < 0) first_done = j;
                last_done = j;
            end
        end
        a_start = 1'b0;
        chk("held_done_count", 24'(dones), 24'd3);
        chk("held_first_done", 24'(first_done), 24'd15);
        chk("held_last_done",  24'(last_done),  24'd45);
        $display("held start: %0d done pulses, first at %0d, last at %0d", dones, first_done, last_done);
        repeat (20) @(negedge clk);

        // Reset in the middle of a conversion
        @(negedge clk);
        a_bin = 14'd1234;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_a_busy",  24'(a_busy),  24'd0);
        chk("abort_a_bcd",   24'(a_bcd),   24'h0);
        chk("abort_a_blank", 24'(a_blank), 24'b1110);
        chk("abort_a_ovf",   24'(a_ovf),   24'd0);
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (a_done) seen = 1;
        end
        chk("abort_no_done", 24'(seen), 24'd0);
        $display("abort: reset mid-conversion, done seen=%0d", seen);
        conv(0, 9999, 24'h009999, 6'b0000, 1'b0, 14);

        // Instance B directed values
        conv(1, 999999,  24'h999999, 6'b000000, 1'b0, 20);
        conv(1, 42,      24'h000042, 6'b111100, 1'b0, 20);
        conv(1, 0,       24'h000000, 6'b111110, 1'b0, 20);
        conv(1, 12345,   24'h012345, 6'b100000, 1'b0, 20);
        conv(1, 1048575, 24'h999999, 6'b000000, 1'b1, 20);
        conv(1, 7,       24'h000007, 6'b111110, 1'b0, 20);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
